// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : uart_pkg
//  Description : Shared types and helpers for the UART receive buffer.
//                UART_DATA_W - payload width of one received character
//                rx_entry_t  - one stored FIFO entry {err, data}
//                ptr_width() - pointer width for a given FIFO depth
//  Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

    localparam int UART_DATA_W = 8;

    typedef struct packed {
        logic                   err;
        logic [UART_DATA_W-1:0] data;
    } rx_entry_t;

    // A depth of 1 would give a zero-width pointer, so clamp to one bit.
    function automatic int ptr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage : uart_pkg
`default_nettype wire

// File: rtl/uart_rx_fifo_if.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo_if
//  Description : Byte-stream handshake bundle around the receive FIFO.
//                rx_*  : strobe-qualified byte from uart_rx (producer side)
//                out_* : first-word-fall-through valid/ready (consumer side)
//                modport slave  - the FIFO
//                modport master - the environment driving bytes in and
//                                 accepting bytes out
//  Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_fifo_if;
    import uart_pkg::*;

    logic [UART_DATA_W-1:0] rx_data;
    logic                   rx_valid;
    logic                   rx_err;
    logic [UART_DATA_W-1:0] out_data;
    logic                   out_err;
    logic                   out_valid;
    logic                   out_ready;

    modport slave (
        input  rx_data, rx_valid, rx_err, out_ready,
        output out_data, out_err, out_valid
    );

    modport master (
        output rx_data, rx_valid, rx_err, out_ready,
        input  out_data, out_err, out_valid
    );

endinterface : uart_rx_fifo_if
`default_nettype wire

// File: rtl/uart_fifo_mem.sv
`default_nettype none
// ============================================================================
//  Module      : uart_fifo_mem
//  Description : Simple dual-port storage array, synchronous write port and
//                asynchronous read port. Contents are not reset; validity is
//                tracked by the owning FIFO.
//  Ports       : clk      - write clock
//                wr_en    - write strobe
//                wr_addr  - write address
//                wr_data  - write data
//                rd_addr  - read address
//                rd_data  - combinational read data
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_fifo_mem
    import uart_pkg::*;
#(
    parameter int DEPTH = 16,
    parameter int WIDTH = 9
) (
    input  logic                         clk,
    input  logic                         wr_en,
    input  logic [ptr_width(DEPTH)-1:0]  wr_addr,
    input  logic [WIDTH-1:0]             wr_data,
    input  logic [ptr_width(DEPTH)-1:0]  rd_addr,
    output logic [WIDTH-1:0]             rd_data
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            r_mem[wr_addr] <= wr_data;
        end
    end

    assign rd_data = r_mem[rd_addr];

endmodule : uart_fifo_mem
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : uart_rx_fifo
//  Description : Circular receive buffer behind uart_rx. Stores each strobed
//                byte with its framing-error flag and presents it through a
//                first-word-fall-through valid/ready port. Reports occupancy,
//                almost-full and a sticky overflow with a saturating count
//                of dropped bytes.
//  Ports       : clk, reset (synchronous, active low)
//                bus          - uart_rx_fifo_if.slave (rx_* in, out_* out)
//                count        - occupancy 0..DEPTH (registered)
//                empty/full   - registered occupancy flags
//                almost_full  - count >= AF_LEVEL (registered)
//                overflow     - sticky, a byte was dropped
//                overflow_clr - clears overflow and drop_cnt
//                drop_cnt     - saturating dropped-byte counter
//                drop_err_cnt - (macro only) saturating errored-byte counter
//  Options     : `define UART_RX_FIFO_DROP_ERR_EN to discard bytes flagged
//                with rx_err instead of storing them; they are counted in
//                drop_err_cnt and out_err is tied low.
//  Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
    import uart_pkg::*;
#(
    parameter int DEPTH      = 16,
    parameter int AF_LEVEL   = 12,
    parameter int DROP_CNT_W = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    uart_rx_fifo_if.slave                 bus,
    output logic [ptr_width(DEPTH):0]     count,
    output logic                          empty,
    output logic                          full,
    output logic                          almost_full,
    output logic                          overflow,
    input  logic                          overflow_clr,
    output logic [DROP_CNT_W-1:0]         drop_cnt
`ifdef UART_RX_FIFO_DROP_ERR_EN
    ,
    output logic [DROP_CNT_W-1:0]         drop_err_cnt
`endif
);

    localparam int PTR_W = ptr_width(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;
    logic [CNT_W-1:0]      w_count_nxt;
    logic                  r_empty;
    logic                  r_full;
    logic                  r_almost_full;
    logic                  r_valid;
    logic                  r_overflow;
    logic [DROP_CNT_W-1:0] r_drop_cnt;
    logic                  w_accept;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;
    rx_entry_t             w_wr_entry;
    rx_entry_t             w_rd_entry;

    // ------------------------------------------------------------------
    // Handshake decode. A full FIFO still accepts a byte when the head is
    // leaving in the same cycle, so the drop path only fires without a pop.
    // ------------------------------------------------------------------
`ifdef UART_RX_FIFO_DROP_ERR_EN
    logic                  w_err_byte;
    logic [DROP_CNT_W-1:0] r_drop_err_cnt;

    assign w_accept   = bus.rx_valid & ~bus.rx_err;
    assign w_err_byte = bus.rx_valid &  bus.rx_err;
    assign w_wr_entry = '{err: 1'b0, data: bus.rx_data};
`else
    assign w_accept   = bus.rx_valid;
    assign w_wr_entry = '{err: bus.rx_err, data: bus.rx_data};
`endif

    assign w_pop  = r_valid & bus.out_ready;
    assign w_push = w_accept & (~r_full | w_pop);
    assign w_drop = w_accept &  r_full & ~w_pop;

    always_comb begin
        w_count_nxt = r_count;
        if (w_push && !w_pop) begin
            w_count_nxt = r_count + CNT_W'(1);
        end else if (w_pop && !w_push) begin
            w_count_nxt = r_count - CNT_W'(1);
        end
    end

    uart_fifo_mem #(
        .DEPTH (DEPTH),
        .WIDTH ($bits(rx_entry_t))
    ) u_mem (
        .clk     (clk),
        .wr_en   (w_push & reset),
        .wr_addr (r_wr_ptr),
        .wr_data (w_wr_entry),
        .rd_addr (r_rd_ptr),
        .rd_data (w_rd_entry)
    );

    // ------------------------------------------------------------------
    // Pointers, occupancy and flags. Flags are derived from the next count
    // so that they are registered alongside it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wr_ptr      <= '0;
            r_rd_ptr      <= '0;
            r_count       <= '0;
            r_empty       <= 1'b1;
            r_full        <= 1'b0;
            r_almost_full <= 1'b0;
            r_valid       <= 1'b0;
            r_overflow    <= 1'b0;
            r_drop_cnt    <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            r_count       <= w_count_nxt;
            r_empty       <= (w_count_nxt == '0);
            r_valid       <= (w_count_nxt != '0);
            r_full        <= (w_count_nxt == CNT_W'(DEPTH));
            r_almost_full <= (w_count_nxt >= CNT_W'(AF_LEVEL));

            // A drop in the clear cycle restarts the count at one.
            if (w_drop) begin
                r_overflow <= 1'b1;
                if (overflow_clr) begin
                    r_drop_cnt <= DROP_CNT_W'(1);
                end else if (r_drop_cnt != '1) begin
                    r_drop_cnt <= r_drop_cnt + DROP_CNT_W'(1);
                end
            end else if (overflow_clr) begin
                r_overflow <= 1'b0;
                r_drop_cnt <= '0;
            end
        end
    end

`ifdef UART_RX_FIFO_DROP_ERR_EN
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_drop_err_cnt <= '0;
        end else if (w_err_byte) begin
            if (overflow_clr) begin
                r_drop_err_cnt <= DROP_CNT_W'(1);
            end else if (r_drop_err_cnt != '1) begin
                r_drop_err_cnt <= r_drop_err_cnt + DROP_CNT_W'(1);
            end
        end else if (overflow_clr) begin
            r_drop_err_cnt <= '0;
        end
    end

    assign drop_err_cnt = r_drop_err_cnt;
    assign bus.out_err  = 1'b0;
`else
    assign bus.out_err  = r_valid & w_rd_entry.err;
`endif

    // Head is masked while empty so the outputs read zero after reset.
    assign bus.out_data  = r_valid ? w_rd_entry.data : '0;
    assign bus.out_valid = r_valid;

    assign count       = r_count;
    assign empty       = r_empty;
    assign full        = r_full;
    assign almost_full = r_almost_full;
    assign overflow    = r_overflow;
    assign drop_cnt    = r_drop_cnt;

endmodule : uart_rx_fifo
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module      : tb_uart_rx_fifo
//  Description : Directed self-checking bench for uart_rx_fifo configured
//                with DEPTH=4, AF_LEVEL=3. Bytes are strobed in directly as
//                uart_rx would present them. Inputs change 1 time unit after
//                the rising edge and outputs are sampled at the same point.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

    localparam int DEPTH      = 4;
    localparam int AF_LEVEL   = 3;
    localparam int DROP_CNT_W = 8;

    logic                  clk = 1'b0;
    logic                  reset;
    logic [2:0]            count;
    logic                  empty;
    logic                  full;
    logic                  almost_full;
    logic                  overflow;
    logic                  overflow_clr;
    logic [DROP_CNT_W-1:0] drop_cnt;
`ifdef UART_RX_FIFO_DROP_ERR_EN
    logic [DROP_CNT_W-1:0] drop_err_cnt;
`endif

    int n_chk  = 0;
    int n_fail = 0;

    uart_rx_fifo_if bus_if ();

    uart_rx_fifo #(
        .DEPTH      (DEPTH),
        .AF_LEVEL   (AF_LEVEL),
        .DROP_CNT_W (DROP_CNT_W)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .bus          (bus_if),
        .count        (count),
        .empty        (empty),
        .full         (full),
        .almost_full  (almost_full),
        .overflow     (overflow),
        .overflow_clr (overflow_clr),
        .drop_cnt     (drop_cnt)
`ifdef UART_RX_FIFO_DROP_ERR_EN
        ,
        .drop_err_cnt (drop_err_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic push(input logic [7:0] data, input logic err);
        bus_if.rx_valid = 1'b1;
        bus_if.rx_data  = data;
        bus_if.rx_err   = err;
        tick();
        bus_if.rx_valid = 1'b0;
        bus_if.rx_data  = 8'hxx;
        bus_if.rx_err   = 1'bx;
    endtask

    task automatic pop();
        bus_if.out_ready = 1'b1;
        tick();
        bus_if.out_ready = 1'b0;
    endtask

    initial begin
        reset            = 1'b0;
        overflow_clr     = 1'b0;
        bus_if.rx_valid  = 1'b0;
        bus_if.rx_data   = 8'h00;
        bus_if.rx_err    = 1'b0;
        bus_if.out_ready = 1'b0;

        // ---- 1: reset held 10 cycles then released ----
        repeat (10) tick();
        reset = 1'b1;
        tick();
        chk("rst_empty",     32'(empty),          32'd1);
        chk("rst_out_valid", 32'(bus_if.out_valid), 32'd0);
        chk("rst_count",     32'(count),          32'd0);
        chk("rst_overflow",  32'(overflow),       32'd0);
        chk("rst_drop_cnt",  32'(drop_cnt),       32'd0);
        chk("rst_full",      32'(full),           32'd0);
        chk("rst_af",        32'(almost_full),    32'd0);
        chk("rst_out_data",  32'(bus_if.out_data), 32'h00);
        chk("rst_out_err",   32'(bus_if.out_err),  32'd0);

        // ---- 2: two bytes in, FWFT readout ----
        push(8'h34, 1'b0);
        chk("fwft_latency",  32'(bus_if.out_valid), 32'd1);
        chk("fwft_head0",    32'(bus_if.out_data),  32'h34);
        push(8'h55, 1'b0);
        chk("two_count",     32'(count),            32'd2);
        chk("two_head",      32'(bus_if.out_data),  32'h34);
        chk("two_err",       32'(bus_if.out_err),   32'd0);
        pop();
        chk("pop1_head",     32'(bus_if.out_data),  32'h55);
        chk("pop1_count",    32'(count),            32'd1);
        pop();
        chk("pop2_empty",    32'(empty),            32'd1);
        chk("pop2_valid",    32'(bus_if.out_valid), 32'd0);

        // ---- 3: fill, almost_full, full, drop (pointers start at 2, wrap) ----
        push(8'h01, 1'b0);
        push(8'h02, 1'b0);
        chk("af_at2",        32'(almost_full),      32'd0);
        push(8'h03, 1'b0);
        chk("af_at3",        32'(almost_full),      32'd1);
        chk("full_at3",      32'(full),             32'd0);
        push(8'h04, 1'b0);
        chk("full_at4",      32'(full),             32'd1);
        chk("count_at4",     32'(count),            32'd4);
        chk("ovf_before",    32'(overflow),         32'd0);
        push(8'h05, 1'b0);
        chk("drop_ovf",      32'(overflow),         32'd1);
        chk("drop_cnt1",     32'(drop_cnt),         32'd1);
        chk("drop_count",    32'(count),            32'd4);
        for (int i = 1; i <= 4; i++) begin
            chk("rb3_data", 32'(bus_if.out_data), 32'(i));
            pop();
        end
        chk("rb3_empty",     32'(empty),            32'd1);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        chk("clr_ovf",       32'(overflow),         32'd0);
        chk("clr_drop",      32'(drop_cnt),         32'd0);

        // ---- 4: push while full together with a pop ----
        for (int i = 0; i < 4; i++) push(8'hA0 + 8'(i), 1'b0);
        chk("f4_full",       32'(full),             32'd1);
        bus_if.rx_valid  = 1'b1;
        bus_if.rx_data   = 8'h10;
        bus_if.rx_err    = 1'b0;
        bus_if.out_ready = 1'b1;
        tick();
        bus_if.rx_valid  = 1'b0;
        bus_if.out_ready = 1'b0;
        chk("pp_count",      32'(count),            32'd4);
        chk("pp_ovf",        32'(overflow),         32'd0);
        chk("pp_full",       32'(full),             32'd1);
        chk("pp_head",       32'(bus_if.out_data),  32'hA1);
        pop();
        chk("rb4_a2",        32'(bus_if.out_data),  32'hA2);
        pop();
        chk("rb4_a3",        32'(bus_if.out_data),  32'hA3);
        pop();
        chk("rb4_last",      32'(bus_if.out_data),  32'h10);
        pop();
        chk("rb4_empty",     32'(empty),            32'd1);

        // ---- 5: errored byte ----
        push(8'hAA, 1'b1);
`ifdef UART_RX_FIFO_DROP_ERR_EN
        chk("err_empty",     32'(empty),            32'd1);
        chk("err_dropcnt",   32'(drop_err_cnt),     32'd1);
        chk("err_ovf",       32'(overflow),         32'd0);
        overflow_clr = 1'b1;
        tick();
        overflow_clr = 1'b0;
        chk("err_clr",       32'(drop_err_cnt),     32'd0);
`else
        chk("err_data",      32'(bus_if.out_data),  32'hAA);
        chk("err_flag",      32'(bus_if.out_err),   32'd1);
        pop();
        chk("err_empty",     32'(empty),            32'd1);
`endif

        // ---- 6: reset mid-operation, clear colliding with a drop ----
        for (int i = 0; i < 5; i++) push(8'h60 + 8'(i), 1'b0);
        chk("r6_ovf",        32'(overflow),         32'd1);
        pop();
        chk("r6_count3",     32'(count),            32'd3);
        chk("r6_head",       32'(bus_if.out_data),  32'h61);
        reset = 1'b0;
        bus_if.rx_valid = 1'b1;
        bus_if.rx_data  = 8'h77;
        bus_if.rx_err   = 1'b0;
        tick();
        bus_if.rx_valid = 1'b0;
        reset = 1'b1;
        chk("r6_empty",      32'(empty),            32'd1);
        chk("r6_count0",     32'(count),            32'd0);
        chk("r6_ovf0",       32'(overflow),         32'd0);
        chk("r6_drop0",      32'(drop_cnt),         32'd0);
        chk("r6_valid0",     32'(bus_if.out_valid), 32'd0);
        for (int i = 0; i < 4; i++) push(8'hC0 + 8'(i), 1'b0);
        chk("r6_head_c0",    32'(bus_if.out_data),  32'hC0);
        overflow_clr = 1'b1;
        push(8'hEE, 1'b0);
        overflow_clr = 1'b0;
        chk("clrdrop_ovf",   32'(overflow),         32'd1);
        chk("clrdrop_cnt",   32'(drop_cnt),         32'd1);
        push(8'hEF, 1'b0);
        chk("drop_cnt2",     32'(drop_cnt),         32'd2);

        // ---- saturation of drop_cnt ----
        bus_if.rx_valid = 1'b1;
        bus_if.rx_data  = 8'h99;
        bus_if.rx_err   = 1'b0;
        repeat (300) tick();
        bus_if.rx_valid = 1'b0;
        chk("drop_sat",      32'(drop_cnt),         32'hFF);
        chk("sat_count",     32'(count),            32'd4);
        chk("sat_head",      32'(bus_if.out_data),  32'hC0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule : tb_uart_rx_fifo
`default_nettype wire
